// File: rtl/score4_pkg.sv
// Shared types, colour constants and default geometry for the score-4 VGA renderer.
package score4_pkg;

  // Default board geometry and display timing
  localparam int DEF_ROWS         = 6;
  localparam int DEF_COLS         = 7;
  localparam int DEF_CELL_W       = 40;
  localparam int DEF_CELL_H       = 40;
  localparam int DEF_H_GAP        = 45;
  localparam int DEF_V_GAP        = 25;
  localparam int DEF_H_ACTIVE     = 640;
  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_BLINK_FRAMES = 30;
  localparam int DEF_CW           = 4;

  // Two-bit cell occupancy code; 2'b11 is reserved and renders black
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P0    = 2'b01,
    P1    = 2'b10
  } cell_t;

  typedef struct packed {
    logic [DEF_CW-1:0] r;
    logic [DEF_CW-1:0] g;
    logic [DEF_CW-1:0] b;
  } rgb_t;

  localparam rgb_t RED   = '{r: '1,            g: '0,            b: '0};
  localparam rgb_t GREEN = '{r: '0,            g: '1,            b: '0};
  localparam rgb_t WHITE = '{r: '1,            g: '1,            b: '1};
  localparam rgb_t GREY  = '{r: DEF_CW'(3),    g: DEF_CW'(3),    b: DEF_CW'(3)};
  localparam rgb_t BLACK = '{r: '0,            g: '0,            b: '0};

  // Leading edge of the i-th cell along one axis: a margin, then i (gap + cell) pitches
  function automatic int cell_lo(input int gap, input int size, input int i);
    return gap + i * (gap + size);
  endfunction

endpackage

// File: rtl/score4_blink_timer.sv
// Frame-counting blink timer: toggles blink_phase every BLINK_FRAMES frame ticks
// while enabled, and holds counter and phase at zero while disabled.
module score4_blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic enable,
  output logic blink_phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] count;

  // Count frame ticks; wrap at LAST and flip the phase, cleared while disabled
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    if (!rst) begin
      count       <= '0;
      blink_phase <= 1'b0;
    end else if (!enable) begin
      count       <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (count == LAST) begin
        count       <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/score4_pixel_renderer.sv
// Score-4 board pixel renderer: stage 1 classifies the h/v position into a cell or
// cursor slot, stage 2 picks the colour from the current game state.
module score4_pixel_renderer
  import score4_pkg::*;
#(
  parameter int ROWS         = DEF_ROWS,
  parameter int COLS         = DEF_COLS,
  parameter int CELL_W       = DEF_CELL_W,
  parameter int CELL_H       = DEF_CELL_H,
  parameter int H_GAP        = DEF_H_GAP,
  parameter int V_GAP        = DEF_V_GAP,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
  parameter int CW           = DEF_CW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [9:0]               h_counter,
  input  logic [9:0]               v_counter,
  input  logic [2*ROWS*COLS-1:0]   panel,
  input  logic [COLS-1:0]          play,
  input  logic                     turn,
  input  logic [ROWS*COLS-1:0]     win_mask,
  input  logic                     game_over,
  output logic [CW-1:0]            red,
  output logic [CW-1:0]            green,
  output logic [CW-1:0]            blue
);

  localparam int IDX_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  // Channel width follows CW here, so colours are built locally rather than from rgb_t
  typedef struct packed {
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
  } pix_t;

  localparam pix_t C_RED   = '{r: '1,       g: '0,       b: '0};
  localparam pix_t C_GREEN = '{r: '0,       g: '1,       b: '0};
  localparam pix_t C_WHITE = '{r: '1,       g: '1,       b: '1};
  localparam pix_t C_GREY  = '{r: CW'(3),   g: CW'(3),   b: CW'(3)};
  localparam pix_t C_BLACK = '{r: '0,       g: '0,       b: '0};

  // Cursor band sits one full pitch below the bottom display line, lower half of a cell
  localparam int CUR_TOP = cell_lo(V_GAP, CELL_H, ROWS) + CELL_H / 2;
  localparam int CUR_BOT = cell_lo(V_GAP, CELL_H, ROWS) + CELL_H;

  int h_pos;
  int v_pos;
  assign h_pos = int'(h_counter);
  assign v_pos = int'(v_counter);

  logic frame_tick;
  logic blink_phase;
  assign frame_tick = (h_counter == 10'd0) && (v_pos == V_ACTIVE);

  score4_blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .enable     (game_over),
    .blink_phase(blink_phase)
  );

  // Stage-1 next values
  logic             active_d;
  logic             hit_cell_d;
  logic [IDX_W-1:0] idx_d;
  logic             hit_cursor_d;
  logic [COL_W-1:0] col_d;

  // Stage-1 registers
  logic             s1_active;
  logic             s1_hit_cell;
  logic [IDX_W-1:0] s1_idx;
  logic             s1_hit_cursor;
  logic [COL_W-1:0] s1_col;

  pix_t pix_d;
  pix_t pix_q;

  // Classify the pixel position: visible area, board cell, or cursor slot
  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch is inferred.
    active_d     = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
    hit_cell_d   = 1'b0;
    idx_d        = '0;
    hit_cursor_d = 1'b0;
    col_d        = '0;
    for (int x = 0; x < COLS; x++) begin
      if (h_pos >= cell_lo(H_GAP, CELL_W, x) && h_pos <= cell_lo(H_GAP, CELL_W, x) + CELL_W) begin
        // Screen slot x is board column COLS-1-x
        for (int y = 0; y < ROWS; y++) begin
          if (v_pos >= cell_lo(V_GAP, CELL_H, y) && v_pos <= cell_lo(V_GAP, CELL_H, y) + CELL_H) begin
            hit_cell_d = 1'b1;
            idx_d      = IDX_W'((ROWS - 1 - y) * COLS + (COLS - 1 - x));
          end
        end
        if (v_pos >= CUR_TOP && v_pos <= CUR_BOT) begin
          hit_cursor_d = 1'b1;
          col_d        = COL_W'(COLS - 1 - x);
        end
      end
    end
  end

  // Stage-1 register: capture the geometric classification
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_active     <= 1'b0;
      s1_hit_cell   <= 1'b0;
      s1_idx        <= '0;
      s1_hit_cursor <= 1'b0;
      s1_col        <= '0;
    end else begin
      s1_active     <= active_d;
      s1_hit_cell   <= hit_cell_d;
      s1_idx        <= idx_d;
      s1_hit_cursor <= hit_cursor_d;
      s1_col        <= col_d;
    end
  end

  // Pick the colour from live game state; earlier branches take priority
  always_comb begin
    pix_d = C_BLACK;
    if (!s1_active) begin
      pix_d = C_BLACK;
    end else if (s1_hit_cursor && play[s1_col] && !game_over) begin
      pix_d = turn ? C_GREEN : C_RED;
    end else if (s1_hit_cell && game_over && win_mask[s1_idx] && blink_phase) begin
      pix_d = C_WHITE;
    end else if (s1_hit_cell) begin
      case (cell_t'(panel[2*s1_idx +: 2]))
        P0:      pix_d = C_RED;
        P1:      pix_d = C_GREEN;
        EMPTY:   pix_d = C_GREY;
        default: pix_d = C_BLACK;
      endcase
    end
  end

  // Stage-2 register: drive the DAC pins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_q <= C_BLACK;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign red   = pix_q.r;
  assign green = pix_q.g;
  assign blue  = pix_q.b;

endmodule

// File: doc/score4_pixel_renderer.md
Name: score4_pixel_renderer

Overview:
- Parametrised VGA pixel renderer for the score-4 board. Sits between the VGA sync/counter generator and the DAC pins.
- Draws a ROWS x COLS grid of cells plus a cursor row. Registered through a fixed 2-stage pipeline.
- Adds grey empty cells, a cursor hidden on game over, and frame-synchronous blinking of winning cells.

Parameters:
- ROWS, 6, board rows (row 0 = bottom)
- COLS, 7, board columns
- CELL_W, 40, cell width in pixels
- CELL_H, 40, cell height in pixels
- H_GAP, 45, horizontal margin/gap in pixels
- V_GAP, 25, vertical margin/gap in pixels
- H_ACTIVE, 640, visible width
- V_ACTIVE, 480, visible height
- BLINK_FRAMES, 30, frames per blink half-period (>=1)
- CW, 4, bits per colour channel

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-low
- h_counter  in  10  current pixel column
- v_counter  in  10  current pixel line
- panel  in  2*ROWS*COLS  cell state; cell (r,c) at bits [2*(r*COLS+c)+:2]; 00 empty, 01 player0, 10 player1, 11 reserved
- play  in  COLS  cursor column mask, bit c = column c
- turn  in  1  0 = player0 (red), 1 = player1 (green)
- win_mask  in  ROWS*COLS  bit r*COLS+c set = winning cell
- game_over  in  1  enables win blink, hides cursor
- red  out  CW  red channel
- green  out  CW  green channel
- blue  out  CW  blue channel

Behaviour:
- Reset (rst=0, async): red/green/blue=0; all pipeline registers, frame counter and blink_phase=0.
- Geometry, screen slot x=0..COLS-1 left to right, maps to column c=COLS-1-x. Display line y=0..ROWS-1 top to bottom, maps to row r=ROWS-1-y. All bounds inclusive.
- Cell hit: h in [H_GAP+x*(H_GAP+CELL_W), H_GAP+CELL_W+x*(H_GAP+CELL_W)] and v in [V_GAP+y*(V_GAP+CELL_H), V_GAP+CELL_H+y*(V_GAP+CELL_H)].
- Cursor hit: same h range. v in [CELL_H/2+V_GAP+ROWS*(V_GAP+CELL_H), V_GAP+CELL_H+ROWS*(V_GAP+CELL_H)].
- Stage 1 (registered):
  - active = (h<H_ACTIVE && v<V_ACTIVE)
  - hit_cell, cell index = r*COLS+c
  - hit_cursor, cursor column c
  - At most one hit per pixel, since regions are disjoint.
- Stage 2 (registered) colour, first match wins:
  1. !active -> 0,0,0
  2. hit_cursor && play[c] && !game_over -> turn ? (0,F,0) : (F,0,0)
  3. hit_cell && game_over && win_mask[idx] && blink_phase -> (F,F,F)
  4. hit_cell, panel 01 -> (F,0,0); 10 -> (0,F,0); 00 -> (3,3,3); 11 -> (0,0,0)
  5. otherwise -> 0,0,0
- F = all ones of width CW; 3 = value 3 zero-extended.
- Latency: output for a pixel appears exactly 2 clk after its h/v sample. Stage 1 samples h/v. Stage 2 samples panel, play, turn, win_mask, game_over and blink_phase in the same cycle it consumes the stage-1 result.
- Blink timer:
  - frame_tick = (h_counter==0 && v_counter==V_ACTIVE), one clk per frame.
  - On frame_tick the counter increments. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - While game_over=0, counter=0 and blink_phase=0 synchronously. The first white phase therefore starts BLINK_FRAMES ticks after game_over rises.
- Multiple bits in play are each drawn in their own slot. play=0 draws no cursor.
- Reset mid-frame forces black immediately. After release, the first valid colour appears 2 clk later.
- Counters at or beyond H_ACTIVE/V_ACTIVE never produce colour, including the cursor row if it falls outside the visible area.

Decomposition:
- Package score4_pkg:
  - cell_t enum (EMPTY=2'b00, P0=2'b01, P1=2'b10)
  - rgb_t struct {r,g,b} of CW bits
  - colour constants RED, GREEN, WHITE, GREY, BLACK
  - default geometry localparams
- Sub-module score4_blink_timer (clk, rst, frame_tick, enable -> blink_phase), parametrised by BLINK_FRAMES.

Test Plan:
1. Reset/black: rst=0 with any inputs -> rgb=0. Release rst, drive h=700,v=100 -> rgb=0 after 2 clk.
2. Cell colour/latency: panel cell idx 41 (r=5,c=6)=01, h=45,v=25 -> (F,0,0) exactly 2 clk later. h=44 -> (0,0,0). Set idx 41=00 -> (3,3,3). Set 10 -> (0,F,0).
3. Bounds: h=85,v=65 with idx 41=01 -> red. h=86 -> black. v=66 -> black. h=130,v=25 (slot 1, idx 40)=10 -> green.
4. Cursor: play=7'b1000000, turn=1, h=60,v=435 -> (0,F,0). v=434 -> black. v=455 -> green. turn=0 -> red. game_over=1 -> black.
5. Blink with BLINK_FRAMES=2: game_over=1, win_mask[41]=1, panel idx 41=01, h=60,v=30:
   - ticks 0-1 -> red
   - after 2nd frame_tick -> (F,F,F)
   - after 4th -> red
   - drop game_over -> red, phase cleared
6. Async reset mid-blink: assert rst between clk edges -> rgb=0 immediately, blink_phase=0 on release.
